// File: rtl/split_vec_loader.sv
// Stream-to-vector loader for one split constraint: assembles NWORDS stream words into a
// wide held vector, samples the constraint result after EVAL_CYC cycles and keeps statistics.
module split_vec_loader #(
  parameter int VEC_W    = 1600,
  parameter int WORD_W   = 16,
  parameter int EVAL_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic [VEC_W-1:0]  vec,
  output logic              vec_valid,
  input  logic              x_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_sat,
  output logic              res_err,
  output logic [31:0]       sat_cnt,
  output logic [31:0]       unsat_cnt,
  output logic [15:0]       err_cnt,
  output logic [1:0]        state_dbg
);

  localparam int NWORDS = (VEC_W + WORD_W - 1) / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NWORDS - 1);
  localparam logic [3:0]       EVAL_LAST = 4'(EVAL_CYC - 1);

  typedef enum logic [1:0] {FILL, DRAIN, EVAL, REPORT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cyc;
  logic             accept;
  logic [VEC_W-1:0] wr_mask;
  logic [VEC_W-1:0] wr_data;

  // Handshake: a stream word moves on a rising edge where in_valid && in_ready; a result
  // record moves where res_valid && res_ready. Both ready/valid are decodes of registered state.
  assign in_ready  = !rst && (state == FILL || state == DRAIN);
  assign res_valid = (state == REPORT);
  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  // Slot select for word idx; bits of the final word beyond VEC_W have no slot and fall away.
  always_comb begin
    wr_mask = '0;
    wr_data = '0;
    for (int b = 0; b < VEC_W; b++) begin
      wr_data[b] = in_data[b % WORD_W];
      if (IDX_W'(b / WORD_W) == idx) wr_mask[b] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      cyc       <= '0;
      vec       <= '0;
      vec_valid <= 1'b0;
      res_sat   <= 1'b0;
      res_err   <= 1'b0;
      sat_cnt   <= '0;
      unsat_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            vec <= (vec & ~wr_mask) | (wr_data & wr_mask);
            if (idx != LAST_IDX) begin
              if (in_last) begin
                state   <= REPORT;
                res_err <= 1'b1;
                res_sat <= 1'b0;
                idx     <= '0;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else begin
              idx <= '0;
              if (in_last) begin
                state     <= EVAL;
                cyc       <= '0;
                vec_valid <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (accept && in_last) begin
            state   <= REPORT;
            res_err <= 1'b1;
            res_sat <= 1'b0;
          end
        end
        EVAL: begin
          cyc <= cyc + 4'd1;
          if (cyc == EVAL_LAST) begin
            res_sat <= x_in;
            res_err <= 1'b0;
            state   <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready) begin
            if (res_err) begin
              if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
            end else if (res_sat) begin
              if (sat_cnt != '1) sat_cnt <= sat_cnt + 32'd1;
            end else begin
              if (unsat_cnt != '1) unsat_cnt <= unsat_cnt + 32'd1;
            end
            state     <= FILL;
            idx       <= '0;
            vec_valid <= 1'b0;
            res_err   <= 1'b0;
            res_sat   <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/split_vec_loader.md
# split_vec_loader

Stimulus loader and result capture stage for one split constraint module. It accepts the constraint's concatenated input variable vector as a stream of fixed-width words and assembles them into a wide, stable vector that drives the constraint's inputs. It then samples the constraint's single-bit result `x` and reports one pass/fail record per vector, keeping running statistics.

## Interface
Parameters:
- `VEC_W`, default 1600: total width of the concatenated variable vector; must equal the sum of the constraint's input widths. Bit 0 is `var_0[0]`.
- `WORD_W`, default 16: stream word width.
- `EVAL_CYC`, default 1 (range 1–15): cycles the vector is held before `x_in` is sampled.
- Derived `NWORDS = ceil(VEC_W/WORD_W)`: words per vector.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  stream word accepted when `in_valid && in_ready`.
- `in_data`  in  WORD_W  stream word.
- `in_last`  in  1  marks the final word of a vector.
- `vec`  out  VEC_W  assembled vector, wired to the constraint inputs.
- `vec_valid`  out  1  `vec` is complete and stable.
- `x_in`  in  1  constraint result.
- `res_valid`  out  1  result record valid.
- `res_ready`  in  1  result record consumed when `res_valid && res_ready`.
- `res_sat`  out  1  sampled `x_in`; 0 when `res_err` is 1.
- `res_err`  out  1  framing error record.
- `sat_cnt`  out  32  vectors with `x_in` = 1; saturates at 2^32−1.
- `unsat_cnt`  out  32  vectors with `x_in` = 0; saturates.
- `err_cnt`  out  16  framing errors; saturates.

## Operation
The FSM has four states: FILL, DRAIN, EVAL and REPORT. Reset state is FILL with word index 0.

**FILL**
- `in_ready` = 1.
- An accepted word k writes `vec[k*WORD_W +: WORD_W]`, clipped to `VEC_W`. Bits of the last word above `VEC_W` are discarded.
- Index k < NWORDS−1 with `in_last` = 1 (short frame): the word is written. The block then posts an error record, goes to REPORT with `res_err` = 1, and resets the index to 0.
- Index k = NWORDS−1 with `in_last` = 0 (long frame): the word is written and the block goes to DRAIN.
- Index k = NWORDS−1 with `in_last` = 1: the block goes to EVAL with its cycle counter at 0.

**DRAIN**
- `in_ready` = 1. Words are accepted and dropped.
- On an accepted word with `in_last` = 1, the block goes to REPORT with `res_err` = 1.

**EVAL**
- `in_ready` = 0 and `vec_valid` = 1. `vec` is frozen.
- The cycle counter increments each cycle. On the cycle it equals EVAL_CYC−1, `x_in` is registered into `res_sat` and the block goes to REPORT.

**REPORT**
- `res_valid` = 1, `in_ready` = 0.
- `vec_valid` remains 1 for a good record and is 0 for an error record.
- Record outputs hold until handshake. On handshake:
  - exactly one counter increments: `res_err` selects `err_cnt`; otherwise `res_sat` selects `sat_cnt` or `unsat_cnt`.
  - the block returns to FILL with index 0 and `vec_valid` = 0.

**Common rules**
- `vec` is never cleared except by reset. Stale bits persist until they are overwritten.
- `x_in` is ignored outside the sampling cycle.
- Counters never wrap.

## Timing
- Reset values: `vec` = 0; `vec_valid`, `res_valid`, `res_sat`, `res_err` = 0; all counters 0; `in_ready` = 0 while `rst` is high.
- `in_ready` is a decode of the registered state only; it has no combinational path from `in_valid`.
- Full-throughput fill takes NWORDS cycles.
- Last word accepted at edge t: `vec_valid` = 1 from t+1, and `x_in` is sampled at edge t+EVAL_CYC.
- With `res_ready` held at 1: `res_valid` is asserted for the single cycle t+EVAL_CYC to t+EVAL_CYC+1. FILL resumes, with `in_ready` = 1, in the following cycle.
- Error record: `res_valid` from the edge after the offending word; no EVAL phase.
- Back-pressure: while `res_ready` = 0, all outputs are held and no word is accepted.
- `rst` asserted in any state, including mid-frame or mid-REPORT: the next edge returns to reset values. A partially filled vector is discarded and no counter increments.

## Test plan
- Setup for all scenarios: `VEC_W`=40, `WORD_W`=16, `EVAL_CYC`=1, `res_ready`=1.
- Send 0x1111, 0x2222, 0xAB33 (last), with `x_in` = 1. Required: `vec` = 0x33_2222_1111, `vec_valid` at t+1, `res_valid` at t+1 with `res_sat` = 1, `sat_cnt` = 1.
- Short frame: 0x0001 with `in_last` = 1. Required: `res_err` = 1, `res_sat` = 0, `err_cnt` = 1, `vec_valid` never 1. The next correct 3-word frame succeeds.
- Long frame: 3 words without `in_last`, then 2 more words, the last with `in_last` = 1. Required: one error record after the 5th word, `err_cnt` = 1, no sat/unsat change.
- `x_in` = 0 with `res_ready` = 0 for 5 cycles. Required: `res_valid` and `vec` are stable, `in_ready` = 0 throughout, and `unsat_cnt` increments exactly once on release.
- Assert `rst` after 2 words of a frame. Required: all outputs are 0 on the next cycle and `in_ready` = 1 after `rst` falls. A fresh frame reports correctly with counters starting from 0.
